systolic_seq_ctrl: RTL and testbench
====================================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for an N x N array of BF16 PE tiles (a/b pass-through, c accumulate).
//  Clears the accumulators, streams K operand beats from the A/B operand buffers with per-lane skew,
//  flushes the wavefront, then walks result rows out to the result buffer. One job per start pulse.
// PARAMETERS
//  N       4  array dimension (rows = cols); N >= 2
//  KW      8  width of k_len; max K = 2^KW-1
//  ADDR_W  8  operand buffer address width; ADDR_W >= KW
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           job request, sampled only in IDLE
//  k_len        in   KW          beats to stream, latched when start is accepted
//  stall        in   1           operand/result buffer not ready; freezes FEED/SKEW/DRAIN
//  busy         out  1           high in every state except IDLE
//  done         out  1           one-cycle completion pulse
//  arr_clear    out  1           synchronous clear of array accumulators (c_in forced to 0)
//  a_rd_en      out  1           A buffer read strobe
//  b_rd_en      out  1           B buffer read strobe (always equal to a_rd_en)
//  rd_addr      out  ADDR_W      shared A/B read address
//  lane_valid   out  N           per-row/col skewed valid; bit i = feed valid delayed i cycles
//  res_capture  out  1           result buffer write strobe
//  res_row      out  $clog2(N)   row being captured
//  abort        in   1           (only with SYSTOLIC_SEQ_ABORT_EN) cancel current job
//  aborted      out  1           (only with SYSTOLIC_SEQ_ABORT_EN) one-cycle cancel pulse
// BEHAVIOUR
//  - Reset (rst_n=0, any state): state=IDLE, every output 0, counters 0, lane_valid=0. Takes effect immediately, mid-job included.
//  - FSM: IDLE -> CLEAR -> FEED -> SKEW -> DRAIN -> DONE -> IDLE. All outputs registered.
//    IDLE : start=1 latches k_len and moves to CLEAR; start while busy is ignored (no queueing).
//    CLEAR: 1 cycle, arr_clear=1. If latched k_len==0 -> DONE (no reads, no capture); else -> FEED.
//    FEED : k_len unstalled cycles; a_rd_en=b_rd_en=1, rd_addr=0..k_len-1, +1 per unstalled cycle.
//    SKEW : 2N-2 unstalled cycles; rd_en=0 so the last beat propagates to PE[N-1][N-1].
//    DRAIN: N unstalled cycles; res_capture=1, res_row=0..N-1.
//    DONE : 1 cycle, done=1, busy=1; next IDLE. A start in this cycle is ignored.
//  - lane_valid: N-bit shift register; bit0 = a_rd_en of the previous cycle, bit i = bit(i-1) of the previous cycle.
//    Shifts only when stall=0; it is 0 in IDLE.
//  - stall=1 in FEED/SKEW/DRAIN holds state, counters, rd_addr, res_row and lane_valid.
//    It also forces a_rd_en/b_rd_en/res_capture to 0 for that cycle. stall is ignored in IDLE/CLEAR/DONE.
//  - Latency, with the start edge = cycle 0 and no stall: CLEAR in cycle 1; FEED in cycles 2..k+1;
//    SKEW in cycles k+2..k+2N-1; DRAIN in cycles k+2N..k+3N-1; done in cycle k+3N.
//    With k=0, done is in cycle 2. Each stalled cycle adds exactly 1.
//  - Counter widths: beat counter KW bits, compared against the latched k_len (no wrap for K <= 2^KW-1);
//    skew counter $clog2(2N-1) bits; row counter $clog2(N) bits. Counters reset to 0 on every state entry.
// CONFIGURATION
//  SYSTOLIC_SEQ_ABORT_EN defined: abort and aborted ports exist.
//    abort=1 in any non-IDLE state, other than DONE, forces IDLE on the next edge.
//    In that cycle aborted=1, done stays 0, and all strobes go to 0 with lane_valid cleared. abort has priority over stall.
//    abort in IDLE or DONE is ignored.
//  SYSTOLIC_SEQ_ABORT_EN undefined: neither port exists; every job runs to DONE.
// TESTING
//  1. N=4, k_len=8, no stall -> arr_clear in cycle 1; rd_addr 0..7 in cycles 2..9;
//     lane_valid[3] high in cycles 6..13; res_row 0..3 in cycles 16..19; done in cycle 20.
//  2. k_len=0 -> arr_clear in cycle 1, done in cycle 2; a_rd_en and res_capture never assert.
//  3. start pulsed in cycles 5 and 20 of the job from (1) -> both ignored; busy stays high; exactly one done.
//  4. k_len=8, stall=1 in cycles 4..6 -> rd_addr holds 2 and rd_en=0 during the stall;
//     addresses still run 0..7 with none skipped; done in cycle 23.
//  5. rst_n=0 in cycle 5 of a k_len=8 job -> busy, rd_en and lane_valid are 0 at once.
//     After release, start runs a clean job as in (1).
//  6. SYSTOLIC_SEQ_ABORT_EN, abort in cycle 12 of job (1) -> aborted=1 in cycle 13; IDLE in cycle 13;
//     done never pulses; a new start completes normally.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic array of BF16 PE tiles.
// A job clears the accumulators, streams k_len operand beats with per-lane skew,
// flushes the wavefront through the array, then walks the result rows out.
// Optional feature: define SYSTOLIC_SEQ_ABORT_EN to add the abort/aborted ports.
module systolic_seq_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned KW     = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 arr_clear,
  output logic                 a_rd_en,
  output logic                 b_rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [N-1:0]         lane_valid,
  output logic                 res_capture,
  output logic [$clog2(N)-1:0] res_row
`ifdef SYSTOLIC_SEQ_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  localparam int unsigned RowW  = $clog2(N);
  localparam int unsigned SkewW = $clog2(2 * N - 1);

  localparam logic [SkewW-1:0] SkewLast = SkewW'(2 * N - 3);
  localparam logic [RowW-1:0]  RowLast  = RowW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StSkew,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      klen_q, klen_d;
  logic [KW-1:0]      beat_q, beat_d;
  logic [SkewW-1:0]   skew_q, skew_d;
  logic [RowW-1:0]    row_q, row_d;

  logic               busy_q;
  logic               done_q;
  logic               clear_q;
  logic               rd_en_q;
  logic               cap_q;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [RowW-1:0]    res_row_q, res_row_d;
  logic [N-1:0]       lane_q, lane_d;
  logic               aborted_q;

  logic               hold;
  logic               abort_req;
  logic               abort_hit;

`ifdef SYSTOLIC_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Stall only freezes the streaming phases; CLEAR and DONE always advance.
  assign hold = stall & ((state_q == StFeed) | (state_q == StSkew) | (state_q == StDrain));

  // Abort is honoured everywhere except IDLE (nothing to cancel) and DONE (already finished).
  assign abort_hit = abort_req & (state_q != StIdle) & (state_q != StDone);

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    skew_d  = skew_q;
    row_d   = row_q;

    if (abort_hit) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            klen_d  = k_len;
            state_d = StClear;
          end
        end
        StClear: begin
          state_d = (klen_q == '0) ? StDone : StFeed;
        end
        StFeed: begin
          if (!stall) begin
            if (beat_q == klen_q - KW'(1)) begin
              state_d = StSkew;
            end else begin
              beat_d = beat_q + KW'(1);
            end
          end
        end
        StSkew: begin
          if (!stall) begin
            if (skew_q == SkewLast) begin
              state_d = StDrain;
            end else begin
              skew_d = skew_q + SkewW'(1);
            end
          end
        end
        StDrain: begin
          if (!stall) begin
            if (row_q == RowLast) begin
              state_d = StDone;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Every state starts its count from zero.
    if (state_d != state_q) begin
      beat_d = '0;
      skew_d = '0;
      row_d  = '0;
    end
  end

  // Address and row outputs are only meaningful in their own phase; zero elsewhere.
  always_comb begin
    rd_addr_d = '0;
    res_row_d = '0;
    if (state_d == StFeed) begin
      rd_addr_d = ADDR_W'(beat_d);
    end
    if (state_d == StDrain) begin
      res_row_d = row_d;
    end
  end

  // Skew shift register: bit 0 takes this cycle's read strobe, higher bits trail by one lane each.
  always_comb begin
    lane_d = lane_q;
    if (state_d == StIdle) begin
      lane_d = '0;
    end else if (!hold) begin
      lane_d = {lane_q[N-2:0], rd_en_q};
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      klen_q  <= '0;
      beat_q  <= '0;
      skew_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      skew_q  <= skew_d;
      row_q   <= row_d;
    end
  end

  // Output registers, decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cap_q     <= 1'b0;
      rd_addr_q <= '0;
      res_row_q <= '0;
      lane_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      clear_q   <= (state_d == StClear);
      rd_en_q   <= (state_d == StFeed);
      cap_q     <= (state_d == StDrain);
      rd_addr_q <= rd_addr_d;
      res_row_q <= res_row_d;
      lane_q    <= lane_d;
      aborted_q <= abort_hit;
    end
  end

  // A stalled cycle must not consume a beat or write a row, so strobes are masked by stall.
  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_clear   = clear_q;
  assign a_rd_en     = rd_en_q & ~hold;
  assign b_rd_en     = rd_en_q & ~hold;
  assign rd_addr     = rd_addr_q;
  assign lane_valid  = lane_q;
  assign res_capture = cap_q & ~hold;
  assign res_row     = res_row_q;

`ifdef SYSTOLIC_SEQ_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (N=4, KW=8, ADDR_W=8).
// A timeline model (job slot number, advanced once per non-stalled cycle) predicts every output
// on every cycle; directed literal checks pin the model to hand-computed cycle numbers.
module tb_systolic_seq_ctrl;

  localparam int N      = 4;
  localparam int KW     = 8;
  localparam int ADDR_W = 8;
  localparam int RowW   = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              stall = 1'b0;
  logic              busy;
  logic              done;
  logic              arr_clear;
  logic              a_rd_en;
  logic              b_rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      lane_valid;
  logic              res_capture;
  logic [RowW-1:0]   res_row;
`ifdef SYSTOLIC_SEQ_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  systolic_seq_ctrl #(
    .N      (N),
    .KW     (KW),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .arr_clear   (arr_clear),
    .a_rd_en     (a_rd_en),
    .b_rd_en     (b_rd_en),
    .rd_addr     (rd_addr),
    .lane_valid  (lane_valid),
    .res_capture (res_capture),
    .res_row     (res_row)
`ifdef SYSTOLIC_SEQ_ABORT_EN
    ,
    .abort       (abort),
    .aborted     (aborted)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int scen     = 0;
  int done_cnt = 0;
  int rel;

  always @(posedge clk) cyc <= cyc + 1;
  always_comb rel = cyc - t0;

  // Job timeline: slot 1 = clear, 2..k+1 = feed, then 2N-2 skew, N drain, one done slot.
  function automatic int done_slot(int k);
    return (k == 0) ? 2 : k + 3 * N;
  endfunction
  function automatic bit in_feed(int s, int k);
    return (k > 0) && (s >= 2) && (s <= k + 1);
  endfunction
  function automatic bit in_drain(int s, int k);
    return (k > 0) && (s >= k + 2 * N) && (s <= k + 3 * N - 1);
  endfunction
  function automatic int lane_exp(int s, int k);
    int v = 0;
    if (s != 0) begin
      for (int i = 0; i < N; i++) begin
        if (in_feed(s - 1 - i, k)) v = v | (1 << i);
      end
    end
    return v;
  endfunction

  int m_slot = 0;
  int m_k    = 0;
  bit m_ab   = 1'b0;

  // Model: advance the slot unless a streaming slot is stalled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot <= 0;
      m_k    <= 0;
      m_ab   <= 1'b0;
    end else begin
      m_ab <= 1'b0;
      if (m_slot == 0) begin
        if (start) begin
          m_slot <= 1;
          m_k    <= int'(k_len);
        end
      end
`ifdef SYSTOLIC_SEQ_ABORT_EN
      else if (abort && (m_slot != done_slot(m_k))) begin
        m_slot <= 0;
        m_ab   <= 1'b1;
      end
`endif
      else if (!(stall && (m_slot >= 2) && (m_slot < done_slot(m_k)))) begin
        m_slot <= (m_slot == done_slot(m_k)) ? 0 : m_slot + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (scenario %0d, job cycle %0d)",
               name, act, exp, scen, rel);
    end
  endtask

  // Single compare process: model check every cycle plus directed literal checks.
  always @(negedge clk) begin
    if (rel == 0) done_cnt <= 0;
    else if (done) done_cnt <= done_cnt + 1;

    chk("busy", int'(busy), int'(m_slot != 0));
    chk("done", int'(done), int'(m_slot != 0 && m_slot == done_slot(m_k)));
    chk("arr_clear", int'(arr_clear), int'(m_slot == 1));
    chk("a_rd_en", int'(a_rd_en), int'(in_feed(m_slot, m_k) && !stall));
    chk("b_rd_en", int'(b_rd_en), int'(in_feed(m_slot, m_k) && !stall));
    chk("rd_addr", int'(rd_addr), in_feed(m_slot, m_k) ? m_slot - 2 : 0);
    chk("lane_valid", int'(lane_valid), lane_exp(m_slot, m_k));
    chk("res_capture", int'(res_capture), int'(in_drain(m_slot, m_k) && !stall));
    chk("res_row", int'(res_row), in_drain(m_slot, m_k) ? m_slot - m_k - 2 * N : 0);
`ifdef SYSTOLIC_SEQ_ABORT_EN
    chk("aborted", int'(aborted), int'(m_ab));
`endif

    if (scen == 0) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_lane", int'(lane_valid), 0);
    end
    if (scen == 1) begin
      if (rel == 1) chk("s1_clear", int'(arr_clear), 1);
      if (rel >= 2 && rel <= 9) begin
        chk("s1_rd_en", int'(a_rd_en), 1);
        chk("s1_addr", int'(rd_addr), rel - 2);
      end
      if (rel == 10) chk("s1_rd_off", int'(a_rd_en), 0);
      if (rel == 5 || rel == 14) chk("s1_lane3_off", int'(lane_valid[N-1]), 0);
      if (rel == 6 || rel == 13) chk("s1_lane3_on", int'(lane_valid[N-1]), 1);
      if (rel >= 16 && rel <= 19) begin
        chk("s1_row", int'(res_row), rel - 16);
        chk("s1_cap", int'(res_capture), 1);
      end
      if (rel == 19 || rel == 21) chk("s1_done_off", int'(done), 0);
      if (rel == 20) chk("s1_done", int'(done), 1);
      if (rel == 21) chk("s1_idle", int'(busy), 0);
    end
    if (scen == 2) begin
      if (rel == 1) chk("s2_clear", int'(arr_clear), 1);
      if (rel == 2) chk("s2_done", int'(done), 1);
      if (rel == 3) chk("s2_idle", int'(busy), 0);
    end
    if (scen == 3) begin
      if (rel == 6 || rel == 19) chk("s3_busy", int'(busy), 1);
      if (rel == 20) chk("s3_done", int'(done), 1);
      if (rel == 21) chk("s3_idle", int'(busy), 0);
      if (rel == 22) chk("s3_no_clear", int'(arr_clear), 0);
      if (rel == 25) chk("s3_one_done", done_cnt, 1);
    end
    if (scen == 4) begin
      if (rel >= 4 && rel <= 6) begin
        chk("s4_hold_addr", int'(rd_addr), 2);
        chk("s4_hold_rd", int'(a_rd_en), 0);
      end
      if (rel == 7) chk("s4_resume_addr", int'(rd_addr), 2);
      if (rel == 7) chk("s4_resume_rd", int'(a_rd_en), 1);
      if (rel == 12) chk("s4_last_addr", int'(rd_addr), 7);
      if (rel == 22) chk("s4_done_off", int'(done), 0);
      if (rel == 23) chk("s4_done", int'(done), 1);
    end
    if (scen == 5 && rel == 5) begin
      chk("s5_busy", int'(busy), 0);
      chk("s5_rd", int'(a_rd_en), 0);
      chk("s5_lane", int'(lane_valid), 0);
    end
    if (scen == 7) begin
      if (rel == 16) chk("s7_done", int'(done), 1);
      if (rel == 17) chk("s7_idle", int'(busy), 0);
    end
`ifdef SYSTOLIC_SEQ_ABORT_EN
    if (scen == 6) begin
      if (rel == 13) chk("s6_aborted", int'(aborted), 1);
      if (rel == 13) chk("s6_idle", int'(busy), 0);
      if (rel == 24) chk("s6_no_done", done_cnt, 0);
    end
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start for one cycle; the cycle it is high is job cycle 0.
  task automatic kick(input int s, input int k);
    scen  = s;
    t0    = cyc;
    start = 1'b1;
    k_len = KW'(k);
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reference job, k=8.
    kick(1, 8);
    repeat (24) step();

    // Empty job.
    kick(2, 0);
    repeat (5) step();

    // Starts during a job and in DONE are dropped.
    kick(3, 8);
    repeat (4) step();
    start = 1'b1;
    k_len = KW'(3);
    step();
    start = 1'b0;
    repeat (14) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();

    // Stall in FEED.
    kick(4, 8);
    repeat (3) step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (20) step();

    // k=1 with stalls in CLEAR, SKEW and DONE.
    kick(7, 1);
    for (int c = 1; c <= 20; c++) begin
      stall = (c == 1 || c == 3 || c == 9 || c == 10 || c == 16);
      step();
    end
    stall = 1'b0;

    // Maximum k with periodic stalls.
    kick(8, 255);
    for (int c = 1; c <= 320; c++) begin
      stall = ((c % 7) == 3);
      step();
    end
    stall = 1'b0;
    repeat (3) step();

    // Reset mid-job, then a clean reference job.
    kick(5, 8);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    kick(1, 8);
    repeat (24) step();

`ifdef SYSTOLIC_SEQ_ABORT_EN
    abort = 1'b1;
    step();
    abort = 1'b0;
    kick(6, 8);
    repeat (11) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (14) step();
    kick(9, 2);
    repeat (20) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
